// File: rtl/seg7_digit_counter_pkg.sv
// seg7_pkg: digit/segment widths, glyph table and encoder.
// SEG_HEX_EN selects a hexadecimal (0..F) digit range instead of 0..9.
package seg7_pkg;

    localparam int DIGIT_W = 4;
    localparam int SEG_W   = 7;

`ifdef SEG_HEX_EN
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd15;
`else
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
`endif

    // bit0 = a ... bit6 = g, active high
    localparam logic [SEG_W-1:0] SEG_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [SEG_W-1:0] seg7_encode(
        input logic [DIGIT_W-1:0] d
    );
        return SEG_GLYPH[d];
    endfunction

endpackage

// File: rtl/seg7_digit_counter_if.sv
// Control/status bundle between the board logic and the digit counter.
// master drives buttons and modes; slave (the counter) drives the display.
interface seg7_digit_counter_if;
    import seg7_pkg::*;

    logic               ena;
    logic               mode_auto;
    logic               btn_up;
    logic               btn_down;
    logic               clear;
    logic [DIGIT_W-1:0] digit;
    logic [SEG_W-1:0]   segments;
    logic               dp;

    modport master (
        output ena, mode_auto, btn_up, btn_down, clear,
        input  digit, segments, dp
    );

    modport slave (
        input  ena, mode_auto, btn_up, btn_down, clear,
        output digit, segments, dp
    );

endinterface

// File: rtl/seg7_digit_counter_btn_debounce.sv
// Button path: 2-flop synchronizer, counting debouncer, rising-edge pulse.
// The synchronizer always runs; everything after it freezes when i_ena is low.
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ena,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_FLIP = CW'(DEB_CYCLES - 2);

    logic          r_s1;
    logic          r_s2;
    logic          r_state;
    logic          r_state_d;
    logic [CW-1:0] r_cnt;
    logic          w_diff;

    assign w_diff  = r_s2 ^ r_state;
    assign o_pulse = r_state & ~r_state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
        end
    end

    // flip on the sample that brings the run of differing samples to DEB_CYCLES-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= 1'b0;
            r_state_d <= 1'b0;
            r_cnt     <= '0;
        end else if (i_ena) begin
            r_state_d <= r_state;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_FLIP) begin
                r_state <= ~r_state;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_digit_counter.sv
// Single-digit up/down/auto counter with registered 7-segment output.
// Build with SEG_HEX_EN defined for a 0..F range; default is 0..9.
module seg7_digit_counter
    import seg7_pkg::*;
#(
    parameter logic [23:0] DIV_MAX    = 24'd9_999_999,
    parameter int          DIV_W      = 24,
    parameter int          DEB_CYCLES = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    seg7_digit_counter_if.slave bus
);

    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(DIV_MAX);

    logic [DIV_W-1:0]   r_div;
    logic [DIGIT_W-1:0] r_digit;
    logic [SEG_W-1:0]   r_seg;
    logic               r_dp;

    logic w_up_pulse;
    logic w_down_pulse;
    logic w_tick;
    logic w_inc;
    logic w_dec;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_ena   (bus.ena),
        .i_btn   (bus.btn_up),
        .o_pulse (w_up_pulse)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_ena   (bus.ena),
        .i_btn   (bus.btn_down),
        .o_pulse (w_down_pulse)
    );

    assign w_tick = (r_div == DIV_TC);
    assign w_inc  = w_up_pulse | (bus.mode_auto & w_tick);
    assign w_dec  = w_down_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_dp  <= 1'b0;
        end else if (bus.ena) begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_dp <= ~r_dp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= '0;
        end else if (bus.ena) begin
            if (bus.clear) begin
                r_digit <= '0;
            end else if (w_inc && w_dec) begin
                r_digit <= r_digit;
            end else if (w_inc) begin
                r_digit <= (r_digit == DIGIT_MAX) ? '0 : r_digit + 4'd1;
            end else if (w_dec) begin
                r_digit <= (r_digit == '0) ? DIGIT_MAX : r_digit - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= 7'h3F;
        end else if (bus.ena) begin
            r_seg <= seg7_encode(r_digit);
        end
    end

    assign bus.digit    = r_digit;
    assign bus.segments = r_seg;
    assign bus.dp       = r_dp;

endmodule

// File: tb/tb_seg7_digit_counter.sv
// Directed + randomized checks of seg7_digit_counter (DEB_CYCLES=4, DIV_MAX=9).
// Expected values come from edge counts since reset and a press-level model.
module tb_seg7_digit_counter;

`ifdef SEG_HEX_EN
    localparam int TB_MAX = 15;
`else
    localparam int TB_MAX = 9;
`endif

    localparam logic [6:0] GLY [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    seg7_digit_counter_if bus ();

    seg7_digit_counter #(
        .DIV_MAX    (24'd9),
        .DIV_W      (24),
        .DEB_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // leaves the bench at the negedge where reset releases (edge count 0)
    task automatic do_reset(input logic auto);
        rst_n = 1'b0;
        bus.mode_auto = auto;
        cyc(3);
        rst_n = 1'b1;
    endtask

    task automatic press(input bit up, input int hi, input int lo);
        if (up) bus.btn_up = 1'b1;
        else    bus.btn_down = 1'b1;
        cyc(hi);
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        cyc(lo);
    endtask

    function automatic int auto_digit(input int k);
        return (k / 10) % (TB_MAX + 1);
    endfunction

    initial begin
        logic [3:0] sd;
        logic [6:0] ss;
        logic       sp;
        logic       pdp;
        int         tog;
        int         md;
        int         op;

        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.ena       = 1'b1;
        bus.mode_auto = 1'b0;
        bus.btn_up    = 1'b0;
        bus.btn_down  = 1'b0;
        bus.clear     = 1'b0;

        // reset values
        cyc(3);
        chk("rst_digit", bus.digit, 0);
        chk("rst_seg", bus.segments, 7'h3F);
        chk("rst_dp", bus.dp, 0);
        rst_n = 1'b1;

        // async reset mid-count
        do_reset(1'b1);
        cyc(35);
        chk("pre_rst_digit", bus.digit, auto_digit(35));
        chk("pre_rst_dp", bus.dp, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_digit", bus.digit, 0);
        chk("async_seg", bus.segments, 7'h3F);
        chk("async_dp", bus.dp, 0);
        cyc(1);
        rst_n = 1'b1;

        // single up press, latency
        do_reset(1'b0);
        bus.btn_up = 1'b1;
        cyc(5);
        chk("up_e5_digit", bus.digit, 0);
        cyc(1);
        chk("up_e6_digit", bus.digit, 1);
        chk("up_e6_seg", bus.segments, 7'h3F);
        cyc(1);
        chk("up_e7_seg", bus.segments, 7'h06);
        cyc(13);
        bus.btn_up = 1'b0;
        cyc(12);
        chk("up_rel_digit", bus.digit, 1);
        chk("up_rel_seg", bus.segments, 7'h06);

        // bounce rejection, then down wrap
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) press(1'b1, 2, 4);
        chk("bounce_digit", bus.digit, 0);
        press(1'b0, 10, 10);
        chk("wrap_dn_digit", bus.digit, TB_MAX);
        chk("wrap_dn_seg", bus.segments, GLY[TB_MAX]);

        // auto mode over 100 cycles
        do_reset(1'b1);
        tog = 0;
        pdp = bus.dp;
        for (int k = 1; k <= 100; k++) begin
            cyc(1);
            chk("auto_digit", bus.digit, auto_digit(k));
            chk("auto_seg", bus.segments, GLY[auto_digit(k - 1)]);
            chk("auto_dp", bus.dp, (k / 10) % 2);
            if (bus.dp !== pdp) tog++;
            pdp = bus.dp;
        end
        chk("auto_dp_toggles", tog, 10);

        // down pulse coincides with tick -> hold
        do_reset(1'b1);
        cyc(4);
        bus.btn_down = 1'b1;
        cyc(6);
        chk("coinc_hold", bus.digit, 0);
        cyc(4);
        bus.btn_down = 1'b0;
        cyc(6);
        chk("coinc_next", bus.digit, 1);

        // same coincidence plus clear -> 0
        do_reset(1'b1);
        cyc(10);
        chk("clr_pre", bus.digit, 1);
        cyc(4);
        bus.btn_down = 1'b1;
        cyc(5);
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        chk("clr_digit", bus.digit, 0);
        cyc(4);
        bus.btn_down = 1'b0;
        cyc(6);
        chk("clr_next", bus.digit, 1);

        // freeze during auto count
        do_reset(1'b1);
        cyc(25);
        bus.ena = 1'b0;
        sd = bus.digit;
        ss = bus.segments;
        sp = bus.dp;
        chk("frz_start", sd, auto_digit(25));
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            chk("frz_digit", bus.digit, sd);
            chk("frz_seg", bus.segments, ss);
            chk("frz_dp", bus.dp, sp);
        end
        bus.ena = 1'b1;
        for (int k = 26; k <= 45; k++) begin
            cyc(1);
            chk("resume_digit", bus.digit, auto_digit(k));
            chk("resume_dp", bus.dp, (k / 10) % 2);
        end

        // randomized clean presses / clears against a press-level model
        do_reset(1'b0);
        md = 0;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            if (op == 0) begin
                press(1'b1, $urandom_range(6, 12), $urandom_range(8, 12));
                md = (md + 1) % (TB_MAX + 1);
            end else if (op == 1) begin
                press(1'b0, $urandom_range(6, 12), $urandom_range(8, 12));
                md = (md + TB_MAX) % (TB_MAX + 1);
            end else if (op == 2) begin
                bus.clear = 1'b1;
                cyc(1);
                bus.clear = 1'b0;
                cyc(2);
                md = 0;
            end else begin
                cyc($urandom_range(1, 5));
            end
            chk("rnd_digit", bus.digit, md);
            chk("rnd_seg", bus.segments, GLY[md]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
